// File: rtl/data_memory_arbiter.sv
// Two-port (CPU/debug) arbiter onto one synchronous RAM: grant 1 cycle after IDLE sample, read data 3 cycles after; losers stall via cpu_stall / held req.
// Contention policy: fixed CPU priority by default, round-robin when ARB_ROUND_ROBIN_EN is defined.
module data_memory_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int BANK_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [BANK_W-1:0]        cpu_bank,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [BANK_W+ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0]        dbg_wdata,
  output logic                     cpu_gnt,
  output logic                     dbg_gnt,
  output logic                     cpu_rvalid,
  output logic                     dbg_rvalid,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic [DATA_W-1:0]        dbg_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [BANK_W+ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     cpu_stall
);
  localparam int MEM_AW = BANK_W + ADDR_W;

  typedef enum logic [1:0] {IDLE, GRANT_CPU, GRANT_DBG, WAIT_RD} state_t;

  state_t              state_q, state_d;
  logic                owner_dbg_q, owner_dbg_d;
  logic                mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic                dbg_rvalid_q, dbg_rvalid_d;
  logic                pick_dbg;

`ifdef ARB_ROUND_ROBIN_EN
  // High when the debug port won the most recent grant.
  logic                last_dbg_q, last_dbg_d;
  assign pick_dbg = dbg_req & (~cpu_req | ~last_dbg_q);
`else
  assign pick_dbg = dbg_req & ~cpu_req;
`endif

  always_comb begin
    state_d      = state_q;
    owner_dbg_d  = owner_dbg_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_dbg_d   = last_dbg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_dbg) begin
          state_d     = GRANT_DBG;
          owner_dbg_d = 1'b1;
          mem_we_d    = dbg_we;
          mem_addr_d  = dbg_addr;
          mem_wdata_d = dbg_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_dbg_d  = 1'b1;
`endif
        end else if (cpu_req) begin
          state_d     = GRANT_CPU;
          owner_dbg_d = 1'b0;
          mem_we_d    = cpu_we;
          mem_addr_d  = {cpu_bank, cpu_addr};
          mem_wdata_d = cpu_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_dbg_d  = 1'b0;
`endif
        end
      end
      GRANT_CPU, GRANT_DBG: begin
        state_d = mem_we_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        state_d = IDLE;
        if (owner_dbg_q) begin
          dbg_rdata_d  = mem_rdata;
          dbg_rvalid_d = 1'b1;
        end else begin
          cpu_rdata_d  = mem_rdata;
          cpu_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_dbg_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dbg_q   <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_dbg_q  <= owner_dbg_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_dbg_q   <= last_dbg_d;
`endif
    end
  end

  assign cpu_gnt    = (state_q == GRANT_CPU);
  assign dbg_gnt    = (state_q == GRANT_DBG);
  assign mem_en     = cpu_gnt | dbg_gnt;
  assign mem_we     = mem_en & mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_stall  = cpu_req & ~cpu_gnt;

endmodule
